// File: rtl/button_ctrl.sv
// rtl/button_ctrl.sv - button synchronizer/debouncer and watch mode/set state machine
// Five raw buttons pass through 2-flop sync and debounce; debounced presses drive the mode FSM.
module button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic [2:0] mode,
    output logic       setValue,
    output logic       upTime,
    output logic       nextd,
    output logic       resetTime
);

    localparam logic [2:0] ST_WATCH     = 3'b000;
    localparam logic [2:0] ST_STOPWATCH = 3'b001;
    localparam logic [2:0] ST_ALARM     = 3'b010;

    localparam int NB      = 5;
    localparam int B_MODE  = 0;
    localparam int B_SET   = 1;
    localparam int B_UP    = 2;
    localparam int B_NEXT  = 3;
    localparam int B_CLEAR = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    s1_q, s2_q, deb_q, press_q;
    logic [NB-1:0]    deb_d, press_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    logic [2:0] mode_q, mode_d;
    logic       set_q, set_d;
    logic       up_q, up_d;
    logic       next_q, next_d;
    logic       clr_q, clr_d;

    assign raw = {btn_clear, btn_next, btn_up, btn_set, btn_mode};

    // A flip happens on the edge where the mismatch run reaches DEBOUNCE_CYCLES;
    // only the 0->1 flip is registered as a press event.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            deb_d[i]   = deb_q[i];
            press_d[i] = 1'b0;
            cnt_d[i]   = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] >= CNT_MAX) begin
                    deb_d[i]   = s2_q[i];
                    press_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Pulses gate on the pre-edge setValue; a set event always pre-empts a mode event.
    always_comb begin
        mode_d = mode_q;
        set_d  = set_q;
        up_d   = press_q[B_UP] & set_q;
        next_d = press_q[B_NEXT] & set_q;
        clr_d  = press_q[B_CLEAR];
        case (mode_q)
            ST_WATCH: begin
                if (press_q[B_SET]) begin
                    set_d = ~set_q;
                end else if (press_q[B_MODE] && !set_q) begin
                    mode_d = ST_STOPWATCH;
                end
            end
            ST_STOPWATCH: begin
                if (!press_q[B_SET] && press_q[B_MODE]) begin
                    mode_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (press_q[B_SET]) begin
                    set_d = ~set_q;
                end else if (press_q[B_MODE] && !set_q) begin
                    mode_d = ST_WATCH;
                end
            end
            default: mode_d = ST_WATCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            mode_q <= ST_WATCH;
            set_q  <= 1'b0;
            up_q   <= 1'b0;
            next_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            mode_q <= mode_d;
            set_q  <= set_d;
            up_q   <= up_d;
            next_q <= next_d;
            clr_q  <= clr_d;
        end
    end

    assign mode      = mode_q;
    assign setValue  = set_q;
    assign upTime    = up_q;
    assign nextd     = next_q;
    assign resetTime = clr_q;

endmodule

// File: tb/tb_button_ctrl.sv
// tb/tb_button_ctrl.sv - randomized and directed bench for button_ctrl against a behavioural model
module tb_button_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_set = 1'b0, btn_up = 1'b0, btn_next = 1'b0, btn_clear = 1'b0;
    logic [2:0] mode;
    logic       setValue, upTime, nextd, resetTime;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // raw bit order: 0 mode, 1 set, 2 up, 3 next, 4 clear
    localparam logic [4:0] M_MODE = 5'b00001, M_SET = 5'b00010, M_UP = 5'b00100,
                           M_NEXT = 5'b01000, M_CLR = 5'b10000;

    button_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_up(btn_up),
        .btn_next(btn_next), .btn_clear(btn_clear),
        .mode(mode), .setValue(setValue), .upTime(upTime), .nextd(nextd), .resetTime(resetTime)
    );

    always #5 clk = ~clk;

    logic [2:0] m_mode;
    bit         m_set, m_up, m_next, m_clr;
    bit         pend [5];
    bit         mdeb [5];
    int         run  [5];
    bit         hist [5][$];

    task automatic model_reset();
        m_mode = 3'd0; m_set = 0; m_up = 0; m_next = 0; m_clr = 0;
        for (int i = 0; i < 5; i++) begin
            pend[i] = 0; mdeb[i] = 0; run[i] = 0; hist[i].delete();
        end
    endtask

    // Events seen at the previous edge become visible on this edge's outputs.
    task automatic model_edge(input logic [4:0] r);
        bit dly;
        m_up   = pend[2] && m_set;
        m_next = pend[3] && m_set;
        m_clr  = pend[4];
        if (pend[1]) begin
            if (m_mode != 3'd1) m_set = !m_set;
        end else if (pend[0] && !m_set) begin
            m_mode = (m_mode == 3'd2) ? 3'd0 : m_mode + 3'd1;
        end
        for (int i = 0; i < 5; i++) begin
            hist[i].push_back(r[i]);
            if (hist[i].size() > 3) void'(hist[i].pop_front());
            dly = (hist[i].size() == 3) ? hist[i][0] : 1'b0;
            pend[i] = 0;
            if (dly != mdeb[i]) begin
                run[i]++;
                if (run[i] == D) begin
                    mdeb[i] = dly;
                    run[i]  = 0;
                    pend[i] = dly;
                end
            end else begin
                run[i] = 0;
            end
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {mode, setValue, upTime, nextd, resetTime};
    endfunction

    function automatic logic [6:0] mdl_vec();
        return {m_mode, m_set, m_up, m_next, m_clr};
    endfunction

    task automatic tick(input logic [4:0] r);
        {btn_clear, btn_next, btn_up, btn_set, btn_mode} = r;
        @(posedge clk);
        #1;
        model_edge(r);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {btn_clear, btn_next, btn_up, btn_set, btn_mode} = 5'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== 7'b0) begin
            errors++; $display("FAIL reset_state got=%b exp=%b", dut_vec(), 7'b0);
        end
        do_reset();
    endtask

    task automatic test_mode_press();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(i < 10 ? M_MODE : 5'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL mode_press cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
            end
            checks++;
            if (mode !== ((i >= 6) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL mode_latency i=%0d got=%0d exp=%0d", i, mode, (i >= 6) ? 1 : 0);
            end
        end
    endtask

    task automatic test_up_gating();
        int pulses;
        logic [4:0] r;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (i < 24) r = ((i % 8) < 3) ? M_UP : 5'b0;
            else r = (i < 34) ? M_UP : 5'b0;
            tick(r);
            if (upTime === 1'b1) pulses++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL up_gated cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL up_suppressed got=%0d pulses exp=0", pulses);
        end
        pulses = 0;
        for (int i = 0; i < 36; i++) begin
            if (i < 8) r = M_SET;
            else if (i < 16) r = 5'b0;
            else if (i < 26) r = M_UP;
            else r = 5'b0;
            tick(r);
            if (upTime === 1'b1) pulses++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL up_enabled cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (pulses !== 1 || setValue !== 1'b1) begin
            errors++; $display("FAIL up_one_pulse got=%0d pulses set=%b exp=1 pulse set=1", pulses, setValue);
        end
    endtask

    task automatic test_alarm_set();
        logic [4:0] seq [6];
        seq = '{M_MODE, M_MODE, M_SET, M_MODE, M_SET, M_MODE};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 16; j++) begin
                tick(j < 8 ? seq[k] : 5'b0);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++; $display("FAIL alarm_set cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
                end
            end
            if (k == 3) begin
                checks++;
                if (mode !== 3'd2 || setValue !== 1'b1) begin
                    errors++; $display("FAIL alarm_mode_blocked got=%0d/%b exp=2/1", mode, setValue);
                end
            end
        end
        checks++;
        if (mode !== 3'd0 || setValue !== 1'b0) begin
            errors++; $display("FAIL alarm_to_watch got=%0d/%b exp=0/0", mode, setValue);
        end
    endtask

    task automatic test_stopwatch_set();
        logic [4:0] seq [3];
        seq = '{M_MODE, M_SET, M_MODE};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 16; j++) begin
                tick(j < 8 ? seq[k] : 5'b0);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++; $display("FAIL sw_set cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
                end
            end
            if (k == 1) begin
                checks++;
                if (mode !== 3'd1 || setValue !== 1'b0) begin
                    errors++; $display("FAIL sw_set_ignored got=%0d/%b exp=1/0", mode, setValue);
                end
            end
        end
        checks++;
        if (mode !== 3'd2) begin
            errors++; $display("FAIL sw_to_alarm got=%0d exp=2", mode);
        end
    endtask

    task automatic test_simultaneous();
        int both, nexts;
        do_reset();
        for (int j = 0; j < 16; j++) begin
            tick(j < 8 ? (M_SET | M_MODE) : 5'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL set_mode_same cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (mode !== 3'd0 || setValue !== 1'b1) begin
            errors++; $display("FAIL set_priority got=%0d/%b exp=0/1", mode, setValue);
        end
        both = 0; nexts = 0;
        for (int j = 0; j < 16; j++) begin
            tick(j < 8 ? (M_CLR | M_NEXT) : 5'b0);
            if (resetTime === 1'b1 && nextd === 1'b1) both++;
            if (nextd === 1'b1) nexts++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL clr_next cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (both !== 1 || nexts !== 1) begin
            errors++; $display("FAIL clr_next_together got both=%0d next=%0d exp 1/1", both, nexts);
        end
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        for (int j = 0; j < 16; j++) tick(j < 8 ? M_MODE : 5'b0);
        for (int j = 0; j < 4; j++) tick(M_MODE);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 7'b0) begin
            errors++; $display("FAIL async_reset got=%b exp=%b", dut_vec(), 7'b0);
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (dut_vec() !== 7'b0) begin
                errors++; $display("FAIL reset_hold got=%b exp=%b", dut_vec(), 7'b0);
            end
        end
        #3;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            tick(M_MODE);
            checks++;
            if (mode !== ((i >= 6) ? 3'd1 : 3'd0) || dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL post_reset_press i=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] r;
        do_reset();
        r = 5'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 6) == 0) r[b] = ~r[b];
            end
            tick(r);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL random cyc=%0d raw=%b got=%b exp=%b", cyc, r, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode_press();
        test_up_gating();
        test_alarm_set();
        test_stopwatch_set();
        test_simultaneous();
        test_reset_mid_debounce();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
